// File: rtl/swan_cipher_core.sv
// swan_cipher_core
//   Iterative SWAN-style Feistel block cipher: one half-round per clock.
//   Decryption runs the key schedule backwards. It therefore needs the final
//   schedule state, which is either precomputed (PRECOMP, HALF_ROUNDS cycles)
//   or taken from a single-entry cache filled by the last precompute.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   request handshake; in_ready == (state == IDLE)
//   mode             0 = encrypt, 1 = decrypt (sampled at accept)
//   key_reuse        decrypt: reuse the cached schedule if it is valid
//   inp, key         block (R = inp[0:S-1], L = inp[S:B-1]) and master key
//   out_valid/ready  result handshake; out = {R,L}, zero while !out_valid
//   busy             high in PRECOMP or ROUND
//
// Bit 0 of every ascending-range port is the MSB of the internal vectors.
// The round subkey is the top SIDE_SIZE bits of the key register. The
// schedule adds rd into the bottom SIDE_SIZE bits of the key register.
module swan_cipher_core #(
  parameter int          BLOCK_SIZE = 128,
  parameter int          KEY_SIZE   = 128,
  parameter int          ROUNDS     = 48,
  parameter int          PD         = 56,
  parameter logic [63:0] DELTA0     = 64'h9e3779b97f4a7c15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic                  key_reuse,
  input  logic [0:BLOCK_SIZE-1] inp,
  input  logic [0:KEY_SIZE-1]   key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:BLOCK_SIZE-1] out,
  output logic                  busy
);

  localparam int SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int HALF_ROUNDS = 2 * ROUNDS;
  localparam int HR_W        = (HALF_ROUNDS > 2) ? $clog2(HALF_ROUNDS) : 1;
  localparam logic [SIDE_SIZE-1:0] DELTA   = SIDE_SIZE'(DELTA0);
  localparam logic [HR_W-1:0]      HR_LAST = HR_W'(HALF_ROUNDS - 1);
  localparam logic [HR_W-1:0]      HR_ONE  = HR_W'(1);

  if (((BLOCK_SIZE & (BLOCK_SIZE - 1)) != 0) || (BLOCK_SIZE < 64) || (BLOCK_SIZE > 256))
  begin : g_bad_block
    $error("swan_cipher_core: BLOCK_SIZE must be 64, 128 or 256");
  end
  if ((KEY_SIZE < BLOCK_SIZE) || ((KEY_SIZE != 128) && (KEY_SIZE != 256)))
  begin : g_bad_key
    $error("swan_cipher_core: KEY_SIZE must be 128 or 256 and >= BLOCK_SIZE");
  end
  if ((PD <= 0) || (PD >= KEY_SIZE) || (ROUNDS < 1)) begin : g_bad_sched
    $error("swan_cipher_core: PD must be in (0, KEY_SIZE) and ROUNDS >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRECOMP, S_ROUND, S_DONE} state_t;

  function automatic logic [SIDE_SIZE-1:0] rotl(input logic [SIDE_SIZE-1:0] x, input int n);
    return (x << n) | (x >> (SIDE_SIZE - n));
  endfunction

  // linear diffusion
  function automatic logic [SIDE_SIZE-1:0] vartheta(input logic [SIDE_SIZE-1:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 7);
  endfunction

  // non-linear layer (AND of two rotations, Simon-like)
  function automatic logic [SIDE_SIZE-1:0] beta(input logic [SIDE_SIZE-1:0] x);
    return x ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
  endfunction

  // quarter-word rotation
  function automatic logic [SIDE_SIZE-1:0] rho(input logic [SIDE_SIZE-1:0] x);
    return rotl(x, SIDE_SIZE / 4);
  endfunction

  state_t                state;
  logic [HR_W-1:0]       hr_q;
  logic                  dec_q;
  logic [SIDE_SIZE-1:0]  r_q, l_q, rd_q;
  logic [KEY_SIZE-1:0]   k_q;
  logic                  cache_valid;
  logic [KEY_SIZE-1:0]   cache_k;
  logic [SIDE_SIZE-1:0]  cache_rd;

  // forward schedule step
  logic [SIDE_SIZE-1:0]  rd_fwd;
  logic [KEY_SIZE-1:0]   k_rot, k_fwd;
  assign rd_fwd = rd_q + DELTA;
  always_comb begin
    k_rot = (k_q >> PD) | (k_q << (KEY_SIZE - PD));
    k_fwd = k_rot;
    k_fwd[SIDE_SIZE-1:0] = k_rot[SIDE_SIZE-1:0] + rd_fwd;
  end

  // inverse schedule step: undo the add, rotate back left, step rd back
  logic [SIDE_SIZE-1:0]  rd_inv;
  logic [KEY_SIZE-1:0]   k_un, k_inv;
  assign rd_inv = rd_q - DELTA;
  always_comb begin
    k_un = k_q;
    k_un[SIDE_SIZE-1:0] = k_q[SIDE_SIZE-1:0] - rd_q;
    k_inv = (k_un << PD) | (k_un >> (KEY_SIZE - PD));
  end

  // Encrypt uses the subkey of the current state and then steps forward.
  // Decrypt steps back first and uses that subkey, so it walks the
  // encrypt subkeys in reverse order.
  logic [SIDE_SIZE-1:0]  sk, x, d, r_nxt, l_nxt;
  logic                  x_is_l;
  assign sk     = dec_q ? k_inv[KEY_SIZE-1 -: SIDE_SIZE] : k_q[KEY_SIZE-1 -: SIDE_SIZE];
  // enc: odd hr -> F(L) into R; dec: odd hr -> F(R) into L
  assign x_is_l = hr_q[0] ^ dec_q;
  assign x      = x_is_l ? l_q : r_q;
  assign d      = rho(vartheta(beta(vartheta(x) ^ sk)));
  assign r_nxt  = x_is_l ? (r_q ^ d) : r_q;
  assign l_nxt  = x_is_l ? l_q : (l_q ^ d);

  logic use_cache;
  assign use_cache = mode && key_reuse && cache_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out         <= '0;
      hr_q        <= '0;
      cache_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dec_q    <= mode;
            r_q      <= inp[0:SIDE_SIZE-1];
            l_q      <= inp[SIDE_SIZE:BLOCK_SIZE-1];
            hr_q     <= HR_LAST;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (use_cache) begin
              k_q   <= cache_k;
              rd_q  <= cache_rd;
              state <= S_ROUND;
            end else begin
              k_q   <= key;
              rd_q  <= '0;
              state <= mode ? S_PRECOMP : S_ROUND;
            end
          end
        end
        S_PRECOMP: begin
          k_q  <= k_fwd;
          rd_q <= rd_fwd;
          if (hr_q == '0) begin
            cache_k     <= k_fwd;
            cache_rd    <= rd_fwd;
            cache_valid <= 1'b1;
            hr_q        <= HR_LAST;
            state       <= S_ROUND;
          end else begin
            hr_q <= hr_q - HR_ONE;
          end
        end
        S_ROUND: begin
          r_q  <= r_nxt;
          l_q  <= l_nxt;
          k_q  <= dec_q ? k_inv : k_fwd;
          rd_q <= dec_q ? rd_inv : rd_fwd;
          if (hr_q == '0) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out       <= {r_nxt, l_nxt};
          end else begin
            hr_q <= hr_q - HR_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/swan_cipher_core.md
SWAN_CIPHER_CORE -- requirements
Module: swan_cipher_core

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning), one per line:
- BLOCK_SIZE, 128, block width in bits; legal values 64, 128, 256.
- KEY_SIZE, 128, key width in bits; legal values 128, 256; must be >= BLOCK_SIZE.
- ROUNDS, 48, full rounds; HALF_ROUNDS = 2*ROUNDS.
- PD, 56, key rotation distance per half-round.
- DELTA0, 64'h9e3779b97f4a7c15, round-delta increment, truncated to SIDE_SIZE = BLOCK_SIZE/2.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on posedge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, request present.
- in_ready, out, 1, core idle and able to accept a request.
- mode, in, 1, 0 = encrypt, 1 = decrypt; sampled at accept.
- key_reuse, in, 1, decrypt only: use the cached precomputed schedule; sampled at accept.
- inp, in, [0:BLOCK_SIZE-1], plaintext or ciphertext.
- key, in, [0:KEY_SIZE-1], master key.
- out_valid, out, 1, result held on out.
- out_ready, in, 1, consumer takes the result.
- out, out, [0:BLOCK_SIZE-1], result.
- busy, out, 1, high in PRECOMP or ROUND.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, PRECOMP, ROUND and DONE, and in_ready SHALL equal (state==IDLE).
REQ-004 On a clock edge with in_valid && in_ready, the block SHALL latch mode, R = inp[0:SIDE_SIZE-1], L = inp[SIDE_SIZE:BLOCK_SIZE-1], master key = key, and rd = 0.
REQ-005 Accepting an encrypt SHALL move the FSM to ROUND with half-round counter hr = HALF_ROUNDS-1.
REQ-006 Accepting a decrypt with (key_reuse==0 or cache_valid==0) SHALL move the FSM to PRECOMP with counter = HALF_ROUNDS-1.
REQ-007 Accepting a decrypt with key_reuse==1 and cache_valid==1 SHALL load the key and rd from the cache and move the FSM directly to ROUND.
REQ-008 Each PRECOMP cycle SHALL perform one forward schedule step: rd += DELTA0; key rotated right by PD; low SIDE_SIZE key bits += rd; all arithmetic modulo 2^SIDE_SIZE.
REQ-009 After exactly HALF_ROUNDS PRECOMP steps, the block SHALL store the key and rd in the cache, set cache_valid = 1, and enter ROUND.
REQ-010 Each ROUND cycle SHALL compute D = rho(vartheta(beta(vartheta(X) ^ sk))), using the encrypt or decrypt schedule per latched mode.
REQ-011 In encrypt mode, an odd hr SHALL select X = L and update R ^= D; an even hr SHALL select X = R and update L ^= D.
REQ-012 In decrypt mode, an odd hr SHALL select X = R and update L ^= D; an even hr SHALL select X = L and update R ^= D.
REQ-013 Each ROUND cycle SHALL advance the key and rd to the next schedule values.
REQ-014 When ROUND completes with hr==0, the FSM SHALL enter DONE.
REQ-015 Latency from the accept edge to out_valid high SHALL be HALF_ROUNDS cycles for encrypt and for cached decrypt, and 2*HALF_ROUNDS cycles for uncached decrypt.
REQ-016 In DONE, out_valid SHALL be 1 and out SHALL equal {R,L}, held stable until out_valid && out_ready.
REQ-017 On the output handshake edge, the FSM SHALL return to IDLE; in_ready SHALL be 1 in the following cycle, so there is no same-cycle turnaround.
REQ-018 in_valid SHALL be ignored outside IDLE; the inputs inp, key, mode and key_reuse SHALL be don't-care after accept.
REQ-019 out SHALL be all-zero whenever out_valid == 0.
REQ-020 busy SHALL equal (state==PRECOMP || state==ROUND).
REQ-021 Any non-power-of-two BLOCK_SIZE, or KEY_SIZE < BLOCK_SIZE, SHALL fail elaboration.

Reset
REQ-022 While rst==1 at a clock edge, the block SHALL force state = IDLE; in_ready = 1 in the next cycle; out_valid = 0; busy = 0; out = 0; hr = 0; cache_valid = 0.
REQ-023 rst asserted mid-PRECOMP, mid-ROUND or in DONE SHALL abort the operation with no result produced; the next decrypt SHALL always precompute.

Verification
REQ-024 Reset: rst = 1 for 2 cycles, then 0 -> in_ready = 1, out_valid = 0, busy = 0, out = 0.
REQ-025 Encrypt (BLOCK_SIZE = 128): inp = 0, key = 0, mode = 0 -> out_valid rises exactly 96 cycles after accept; out matches the team C model.
REQ-026 Decrypt fresh: previous ciphertext, key = 0, mode = 1, key_reuse = 0 -> out_valid after 192 cycles, out = 0.
REQ-027 Decrypt cached: repeat the previous step with key_reuse = 1 -> out_valid after 96 cycles, out = 0; the same request after reset -> 192 cycles.
REQ-028 Backpressure: out_ready = 0 for 10 cycles in DONE -> out stable, in_ready = 0, and a new in_valid is ignored; after out_ready = 1 -> in_ready = 1 next cycle.
REQ-029 Abort: rst pulse at ROUND cycle 40 -> next cycle out_valid = 0 and in_ready = 1; a following key_reuse = 1 decrypt takes 192 cycles.
